// File: rtl/id_exe_skid_reg.sv
// ID->EXE boundary: two-entry skid buffer (main + skid) carrying the decoded
// control word and operands, with flush, bubble gating and a stall counter.
module id_exe_skid_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_exec_cmd,
  input  logic                  in_mem_r_en,
  input  logic                  in_mem_w_en,
  input  logic                  in_wb_en,
  input  logic                  in_is_imm,
  input  logic [1:0]            in_branch_type,
  input  logic                  in_single_src,
  input  logic [DATA_W-1:0]     in_pc,
  input  logic [DATA_W-1:0]     in_val1,
  input  logic [DATA_W-1:0]     in_val2,
  input  logic [DATA_W-1:0]     in_st_val,
  input  logic [REG_ADDR_W-1:0] in_dest,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_exec_cmd,
  output logic                  out_mem_r_en,
  output logic                  out_mem_w_en,
  output logic                  out_wb_en,
  output logic                  out_is_imm,
  output logic [1:0]            out_branch_type,
  output logic                  out_single_src,
  output logic [DATA_W-1:0]     out_pc,
  output logic [DATA_W-1:0]     out_val1,
  output logic [DATA_W-1:0]     out_val2,
  output logic [DATA_W-1:0]     out_st_val,
  output logic [REG_ADDR_W-1:0] out_dest,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int PAY_W = 11 + 4 * DATA_W + REG_ADDR_W;

  logic             main_valid;
  logic             skid_valid;
  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] main_pay;
  logic [PAY_W-1:0] skid_pay;
  logic             accept;
  logic             emit;
  logic             refill;
  logic             main_mem_r_en;
  logic             main_mem_w_en;
  logic             main_wb_en;
  logic [1:0]       main_branch_type;

  assign in_pay = {in_exec_cmd, in_mem_r_en, in_mem_w_en, in_wb_en, in_is_imm,
                   in_branch_type, in_single_src, in_pc, in_val1, in_val2,
                   in_st_val, in_dest};

  // skid_valid is a flop, so in_ready has no combinational path from either side
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign emit     = main_valid & out_ready;
  assign refill   = ~main_valid | emit;

  // ---- occupancy control ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (refill) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= accept;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
    end
  end

  // ---- main entry payload (head of the FIFO, drives out_*) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_pay <= '0;
    end else if (!flush && refill && (skid_valid || accept)) begin
      main_pay <= skid_valid ? skid_pay : in_pay;
    end
  end

  // ---- skid entry payload ----
  always_ff @(posedge clk) begin
    if (!flush && !refill && accept) begin
      skid_pay <= in_pay;
    end
  end

  // ---- back-pressure counter, saturating ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign {out_exec_cmd, main_mem_r_en, main_mem_w_en, main_wb_en, out_is_imm,
          main_branch_type, out_single_src, out_pc, out_val1, out_val2,
          out_st_val, out_dest} = main_pay;

  // Side-effecting fields read as a NOP whenever the head is empty
  assign out_valid       = main_valid;
  assign out_mem_r_en    = main_mem_r_en & main_valid;
  assign out_mem_w_en    = main_mem_w_en & main_valid;
  assign out_wb_en       = main_wb_en & main_valid;
  assign out_branch_type = main_branch_type & {2{main_valid}};

endmodule
